// File: rtl/mul_shift.sv
// Sequential signed fixed-point multiplier: out = sat(round((in0*in1) >>> shift)), radix-2 shift-add.
// Latency 17 edges after acceptance (done registered); once is ignored while busy, nothing is queued.
module mul_shift #(
    parameter int W  = 16,
    parameter int SW = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                once,
    output logic                done,
    output logic                busy,
    input  logic [W-1:0]        in0,
    input  logic [W-1:0]        in1,
    input  logic [SW-1:0]       shift,
    output logic [W-1:0]        out
);
    localparam int CW = $clog2(W) + 1;
    localparam logic signed [2*W:0] SAT_MAX = (2**(W-1)) - 1;
    localparam logic signed [2*W:0] SAT_MIN = -(2**(W-1));

    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    state_t              state_q;
    logic [W-1:0]        mcand_q;
    logic [W-1:0]        mplier_q;
    logic [2*W-1:0]      acc_q;
    logic                sign_q;
    logic [SW-1:0]       shift_q;
    logic [CW-1:0]       count_q;
    logic                done_q;
    logic                busy_q;
    logic [W-1:0]        out_q;

    logic [W-1:0]        abs0_d;
    logic [W-1:0]        abs1_d;
    logic [2*W-1:0]      acc_d;
    logic signed [2*W:0] prod_d;
    logic signed [2*W:0] rnd_d;
    logic signed [2*W:0] sum_d;
    logic signed [2*W:0] shr_d;
    logic [W-1:0]        out_d;

    // Magnitudes are unsigned W bits, so the most negative operand maps to 2**(W-1) exactly.
    always_comb begin
        abs0_d = in0[W-1] ? (~in0 + 1'b1) : in0;
        abs1_d = in1[W-1] ? (~in1 + 1'b1) : in1;
        acc_d  = acc_q;
        if (mplier_q[0])
            acc_d = acc_q + ({{W{1'b0}}, mcand_q} << count_q);
    end

    always_comb begin
        prod_d = sign_q ? -$signed({1'b0, acc_q}) : $signed({1'b0, acc_q});
        rnd_d  = '0;
        if (shift_q != '0)
            rnd_d = $signed({{(2*W){1'b0}}, 1'b1}) <<< (shift_q - 1'b1);
        sum_d  = prod_d + rnd_d;
        shr_d  = sum_d >>> shift_q;
        if (shr_d > SAT_MAX)
            out_d = SAT_MAX[W-1:0];
        else if (shr_d < SAT_MIN)
            out_d = SAT_MIN[W-1:0];
        else
            out_d = shr_d[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            shift_q  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (once) begin
                        mcand_q  <= abs0_d;
                        mplier_q <= abs1_d;
                        sign_q   <= in0[W-1] ^ in1[W-1];
                        shift_q  <= shift;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (count_q == CW'(W-1))
                        state_q <= NORM;
                end
                NORM: begin
                    out_q   <= out_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done = done_q;
    assign busy = busy_q;
    assign out  = out_q;
endmodule

// File: tb/tb_mul_shift.sv
// Directed bench for mul_shift: latency, rounding, saturation, ignored/held once, async reset abort.
module tb_mul_shift;
    logic        clk;
    logic        rst;
    logic        once;
    logic        done;
    logic        busy;
    logic [15:0] in0;
    logic [15:0] in1;
    logic [3:0]  shift;
    logic [15:0] out;

    int n_cmp;
    int n_bad;

    mul_shift #(.W(16), .SW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .once  (once),
        .done  (done),
        .busy  (busy),
        .in0   (in0),
        .in1   (in1),
        .shift (shift),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for done; lat = edges after acceptance, -1 on timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          output int lat, output logic [15:0] res, output int busy_cnt);
        @(negedge clk);
        in0 = a; in1 = b; shift = s; once = 1'b1;
        @(posedge clk); #1;
        once = 1'b0;
        in0 = 16'hDEAD; in1 = 16'hBEEF; shift = 4'hA;
        lat = -1; res = 16'hxxxx; busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                res = out;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; once = 1'b0; in0 = '0; in1 = '0; shift = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({done, busy, out} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_state: done=%b busy=%b out=%h, want 0 0 0000", done, busy, out);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat; int bc; logic [15:0] r;
        run_op(16'h0100, 16'h0180, 4'd8, lat, r, bc);
        n_cmp++;
        if (lat !== 17) begin n_bad++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_cmp++;
        if (r !== 16'h0180) begin n_bad++; $display("FAIL basic_out: got %h want 0180", r); end
        n_cmp++;
        if (bc !== 17) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || out !== 16'h0180) begin
            n_bad++;
            $display("FAIL basic_done_pulse_hold: done=%b out=%h want 0 0180", done, out);
        end
    endtask

    task automatic test_vectors;
        logic [15:0] a [8] = '{16'hFFFD, 16'h0003, 16'hFFFD, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0007};
        logic [15:0] b [8] = '{16'h0005, 16'h0001, 16'h0001, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE};
        logic [3:0]  s [8] = '{4'd0,     4'd1,     4'd1,     4'd15,    4'd0,     4'd15,    4'd0,     4'd2};
        logic [15:0] e [8] = '{16'hFFF1, 16'h0002, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h0000, 16'hFFFD};
        int lat; int bc; logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            run_op(a[i], b[i], s[i], lat, r, bc);
            n_cmp++;
            if (lat !== 17 || r !== e[i]) begin
                n_bad++;
                $display("FAIL vector_%0d: in0=%h in1=%h sh=%0d lat=%0d out=%h want lat 17 out %h",
                         i, a[i], b[i], s[i], lat, r, e[i]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int dones; int first;
        @(negedge clk);
        in0 = 16'hFFFD; in1 = 16'h0005; shift = 4'd0; once = 1'b1;
        @(posedge clk); #1;
        once = 1'b0;
        dones = 0; first = -1;
        for (int i = 1; i <= 45; i++) begin
            once = (i == 3 || i == 10);
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        once = 1'b0;
        n_cmp++;
        if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        n_cmp++;
        if (first !== 17 || out !== 16'hFFF1) begin
            n_bad++;
            $display("FAIL ignore_result: lat=%0d out=%h want 17 FFF1", first, out);
        end
    endtask

    task automatic test_back_to_back;
        int t [3]; int k;
        @(negedge clk);
        in0 = 16'h0002; in1 = 16'h0005; shift = 4'd0; once = 1'b1;
        k = 0;
        for (int i = 0; i < 80 && k < 3; i++) begin
            @(posedge clk); #1;
            if (done) begin t[k] = i; k++; end
        end
        once = 1'b0;
        n_cmp++;
        if (k !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d dones want 3", k);
        end else begin
            n_cmp++;
            if (t[0] !== 17 || t[1] - t[0] !== 18 || t[2] - t[1] !== 18) begin
                n_bad++;
                $display("FAIL b2b_spacing: edges %0d %0d %0d want 17 35 53", t[0], t[1], t[2]);
            end
            n_cmp++;
            if (out !== 16'h000A) begin n_bad++; $display("FAIL b2b_out: got %h want 000A", out); end
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        int dones; int lat; int bc; logic [15:0] r;
        @(negedge clk);
        in0 = 16'h0100; in1 = 16'h0100; shift = 4'd0; once = 1'b1;
        @(posedge clk); #1;
        once = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b done=%b out=%h want 0 0 0000", busy, done, out);
        end
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        n_cmp++;
        if (dones !== 0 || busy !== 1'b0 || out !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort_no_done: dones=%0d busy=%b out=%h want 0 0 0000", dones, busy, out);
        end
        run_op(16'h0002, 16'h0003, 4'd0, lat, r, bc);
        n_cmp++;
        if (lat !== 17 || r !== 16'h0006) begin
            n_bad++;
            $display("FAIL after_reset_op: lat=%0d out=%h want 17 0006", lat, r);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_shift.md
Name: mul_shift

Overview:
- Sequential signed fixed-point multiplier with the same start/done handshake, operand ports and shift port as the team's divider; it is the inverse-operation companion in the lock-loop arithmetic path.
- Computes out = sat16(round((in0 * in1) >> shift)) using a radix-2 shift-add datapath.
- A loop controller can issue a multiply and a divide with identical sequencing logic.

Parameters:
- W, 16, operand and result width; only 16 is verified.
- SW, 4, width of the shift port.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- once  input  1  start request, sampled only while idle
- done  output  1  one-cycle pulse; out is valid and updated in the same cycle
- busy  output  1  high from the accepting edge until the edge that raises done
- in0  input  16  signed two's-complement multiplicand
- in1  input  16  signed two's-complement multiplier
- shift  input  4  right-shift amount 0..15 applied to the 32-bit product
- out  output  16  signed saturated result; holds until the next completion

Behaviour:
- Reset: rst high forces state IDLE, count=0, done=0, busy=0, out=16'h0000 and clears all internal registers, immediately and regardless of clk.
- Reset mid-operation aborts the operation. No done pulse is generated for the aborted operation.

State machine:
- IDLE:
  - once=1 at a rising edge latches |in0| and |in1| (16-bit unsigned; 0x8000 gives 32768).
  - It also latches sign = in0[15]^in1[15] and shift, clears the 32-bit accumulator, sets count=0 and busy=1, and goes to MUL.
  - once=0 means stay in IDLE.
- MUL: 16 edges.
  - Each edge: if multiplier LSB=1, accumulator += multiplicand << count; shift the multiplier right by 1; count += 1.
  - After the 16th MUL edge, go to NORM.
- NORM: 1 edge.
  - p = signed 33-bit product, negated when sign=1.
  - If shift>0, p += 1 << (shift-1) (round half toward +infinity).
  - r = p >>> shift (arithmetic shift).
  - out <= r clamped to [-32768, 32767].
  - done <= 1, busy <= 0, go to IDLE.

Timing and handshake:
- Latency: done is high in the cycle after the 17th edge following the accepting edge, so back-to-back issue gives one result per 18 cycles.
- done is high exactly one cycle. out changes only on the edge that raises done.
- once while busy=1 is ignored and not queued. Inputs may change freely after the accepting edge.
- once held high continuously: a new operation is accepted on the edge where done rises. The edge-producing-done returns to IDLE, so acceptance happens on the following edge, giving one result per 18 cycles.
- shift=0: no rounding term; result is the low product saturated.
- shift=15: rounding term is 0x4000.
- Zero operands: out=0 with no negative zero, since the negation of 0 is 0.
- No other special cases; shift=0 and shift=15 use the normal datapath.

Test Plan:
- in0=0x0100, in1=0x0180, shift=8, once for 1 cycle → done pulses 17 edges after acceptance; out=0x0180; busy high for exactly those cycles.
- in0=0xFFFD (-3), in1=0x0005, shift=0 → out=0xFFF1.
- Rounding checks:
  - in0=3, in1=1, shift=1 → out=0x0002.
  - in0=0xFFFD, in1=1, shift=1 → out=0xFFFF (-1, half rounds toward +infinity).
- Saturation checks:
  - in0=0x8000, in1=0x8000, shift=15 → out=0x7FFF.
  - in0=0x7FFF, in1=0x7FFF, shift=0 → 0x7FFF.
  - in0=0x7FFF, in1=0x8000, shift=15 → 0x8001.
- once pulsed again at edges 3 and 10 of a busy operation → ignored: exactly one done, result unchanged. once held high → done every 18 cycles.
- rst asserted asynchronously mid-MUL (edge 5), then released → done never pulses for that operation; out=0x0000, busy=0. A subsequent op (in0=2, in1=3, shift=0) returns out=0x0006.
